// File: rtl/time2cntalm.sv
// Packed-decimal time (HH*10000+MM*100+SS) to seconds count using two bit-serial divides by 100.
// Optional TIME2CNT_CLAMP_EN: clamp out-of-range fields instead of returning zero.
module time2cntalm #(
  parameter int unsigned HOUR_MAX = 24,
  parameter int unsigned CNT_W    = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [19:0]      time_i,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_o
);

  typedef enum logic [1:0] {StIdle, StDiv1, StDiv2, StCalc} state_e;

  state_e           r_state, w_state_nxt;
  logic [19:0]      r_div, w_div_nxt;
  logic [6:0]       r_rem, w_rem_nxt;
  logic [6:0]       r_ss, w_ss_nxt;
  logic [4:0]       r_bit, w_bit_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_err, w_err_nxt;

  // One restoring-division step: remainder stays below 100, so the trial fits in 8 bits.
  logic [7:0]  w_trial;
  logic        w_ge;
  logic [6:0]  w_rem_step;
  logic [19:0] w_div_step;

  assign w_trial    = {r_rem, r_div[19]};
  assign w_ge       = (w_trial >= 8'd100);
  assign w_rem_step = w_ge ? (w_trial[6:0] - 7'd100) : w_trial[6:0];
  assign w_div_step = {r_div[18:0], w_ge};

  logic [CNT_W-1:0] w_hh, w_mm, w_ss, w_hh_c, w_mm_c, w_ss_c, w_sum, w_cnt_calc;
  logic             w_err_calc;

  assign w_hh = CNT_W'(r_div[13:0]);
  assign w_mm = CNT_W'(r_rem);
  assign w_ss = CNT_W'(r_ss);

  assign w_err_calc = (w_ss > CNT_W'(59)) | (w_mm > CNT_W'(59)) | (w_hh > CNT_W'(HOUR_MAX));

`ifdef TIME2CNT_CLAMP_EN
  assign w_hh_c = (w_hh > CNT_W'(HOUR_MAX)) ? CNT_W'(HOUR_MAX) : w_hh;
  assign w_mm_c = (w_mm > CNT_W'(59)) ? CNT_W'(59) : w_mm;
  assign w_ss_c = (w_ss > CNT_W'(59)) ? CNT_W'(59) : w_ss;
`else
  assign w_hh_c = w_hh;
  assign w_mm_c = w_mm;
  assign w_ss_c = w_ss;
`endif

  // HH*3600 + MM*60 + SS as shift-adds.
  assign w_sum = (w_hh_c << 11) + (w_hh_c << 10) + (w_hh_c << 9) + (w_hh_c << 4)
               + (w_mm_c << 6) - (w_mm_c << 2) + w_ss_c;

`ifdef TIME2CNT_CLAMP_EN
  assign w_cnt_calc = w_sum;
`else
  assign w_cnt_calc = w_err_calc ? '0 : w_sum;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_rem_nxt   = r_rem;
    w_ss_nxt    = r_ss;
    w_bit_nxt   = r_bit;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_nxt = StDiv1;
          w_div_nxt   = time_i;
          w_rem_nxt   = '0;
          w_bit_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      StDiv1: begin
        w_div_nxt = w_div_step;
        w_rem_nxt = w_rem_step;
        w_bit_nxt = r_bit + 5'd1;
        if (r_bit == 5'd19) begin
          // q1 fits in 14 bits; left-align it so the same MSB-first step serves DIV2.
          w_ss_nxt    = w_rem_step;
          w_div_nxt   = {w_div_step[13:0], 6'd0};
          w_rem_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = StDiv2;
        end
      end
      StDiv2: begin
        w_div_nxt = w_div_step;
        w_rem_nxt = w_rem_step;
        w_bit_nxt = r_bit + 5'd1;
        if (r_bit == 5'd13) begin
          w_state_nxt = StCalc;
        end
      end
      StCalc: begin
        w_cnt_nxt   = w_cnt_calc;
        w_err_nxt   = w_err_calc;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_div   <= '0;
      r_rem   <= '0;
      r_ss    <= '0;
      r_bit   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_rem   <= w_rem_nxt;
      r_ss    <= w_ss_nxt;
      r_bit   <= w_bit_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign cnt_o = r_cnt;
  assign err_o = r_err;

endmodule
